// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl
//   Shares one show-ahead FIFO between N_REQ producers and a single consumer.
//   Producers are served by a round-robin write arbiter. Words are popped from
//   the FIFO into a registered valid/ready output stage. A flush sequence
//   clears the FIFO through clear_n_o and discards the output word.
//
//   Optional feature macro: FIFO_RR_STATS_EN
//     When defined, adds stall_cnt_o. This holds one saturating 16-bit counter
//     per producer that counts the cycles in which req_i[i]=1 and gnt_o[i]=0.
//     The counters are cleared by reset and by flush_i.
//
// Ports
//   clock_i, reset_n_i       clock (rising edge), async active-low reset
//   enable_i                 allow grants and pops
//   flush_i                  1-cycle pulse that discards FIFO and output contents
//   req_i, req_data_i        per-producer request and word (producer i at [i*DATA_W +: DATA_W])
//   gnt_o                    one-hot grant; the granted word is written on this edge
//   out_data_o, out_valid_o  consumer word and its valid flag
//   out_ready_i              consumer accepts when out_valid_o & out_ready_i
//   almost_full_o            use_dw_i >= AFULL_LVL or FIFO full
//   busy_flush_o             flush sequence in progress
//   write_o, read_o          FIFO write and read strobes
//   clear_n_o                FIFO clear (active low)
//   data_in_o                FIFO write data
//   data_out_i               FIFO head word (show-ahead)
//   f_full_n_i, f_empty_n_i  FIFO status (active low)
//   use_dw_i                 FIFO fill level
//   stall_cnt_o              (FIFO_RR_STATS_EN only) per-producer stall counters
//
// States
//   state      | meaning
//   IDLE       | no grants or pops; the output word holds until the consumer takes it
//   RUN        | arbitration and popping active
//   FLUSH_CLR  | clear_n_o asserted for one cycle
//   FLUSH_WAIT | wait for the FIFO to report empty
module fifo_rr_ctrl #(
  parameter int DATA_W    = 8,
  parameter int N_REQ     = 2,
  parameter int UDW_W     = 5,
  parameter int AFULL_LVL = 28
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [DATA_W-1:0]       out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    almost_full_o,
  output logic                    busy_flush_o,
  output logic                    write_o,
  output logic                    read_o,
  output logic                    clear_n_o,
  output logic [DATA_W-1:0]       data_in_o,
  input  logic [DATA_W-1:0]       data_out_i,
  input  logic                    f_full_n_i,
  input  logic                    f_empty_n_i,
  input  logic [UDW_W-1:0]        use_dw_i
`ifdef FIFO_RR_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     stall_cnt_o
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [UDW_W-1:0] AFULL_V = UDW_W'(AFULL_LVL);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    FLUSH_CLR  = 2'd2,
    FLUSH_WAIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic               win_vld;
  logic               grant_en;

  // Next-state logic. A flush request overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = FLUSH_CLR;
    end else begin
      case (state_q)
        IDLE:       if (enable_i) state_d = RUN;
        RUN:        if (!enable_i) state_d = IDLE;
        FLUSH_CLR:  state_d = FLUSH_WAIT;
        FLUSH_WAIT: if (!f_empty_n_i) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Round-robin search. The loop scans offsets from the highest down to 0,
  // so the requester closest to the pointer is the last one written and wins.
  always_comb begin
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // f_full_n_i is the status before the edge, so a pop in the same cycle
  // does not free a slot for a grant.
  assign grant_en = (state_q == RUN) && f_full_n_i && !flush_i;

  always_comb begin
    gnt_o    = '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_en && win_vld) begin
      gnt_o[win_idx] = 1'b1;
      rr_ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  assign write_o   = |gnt_o;
  assign data_in_o = req_data_i[int'(win_idx)*DATA_W +: DATA_W];

  assign read_o = (state_q == RUN) && !flush_i && f_empty_n_i &&
                  (!out_valid_q || out_ready_i);

  // Output register. The consumer can still take the held word in IDLE.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (read_o) begin
      out_valid_d = 1'b1;
      out_data_d  = data_out_i;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign clear_n_o     = (state_q != FLUSH_CLR);
  assign busy_flush_o  = (state_q == FLUSH_CLR) || (state_q == FLUSH_WAIT);
  // use_dw_i wraps when the FIFO is completely full, so full comes from f_full_n_i.
  assign almost_full_o = (use_dw_i >= AFULL_V) || !f_full_n_i;

`ifdef FIFO_RR_STATS_EN
  logic [15:0] stall_q [N_REQ];
  logic [15:0] stall_d [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stall_d[i] = stall_q[i];
      if (flush_i) begin
        stall_d[i] = '0;
      end else if (req_i[i] && !gnt_o[i] && (stall_q[i] != 16'hFFFF)) begin
        stall_d[i] = stall_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < N_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) stall_q[i] <= stall_d[i];
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stall
    assign stall_cnt_o[g*16 +: 16] = stall_q[g];
  end
`endif

endmodule
